// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment/range checking, byte/half read-modify-write,
// big-endian lane extraction and extension in front of a 1-cycle word-wide data memory.
module mem_access_unit #(
    parameter logic [31:0] BASE_WORD  = 32'h4B00,
    parameter int          ADDR_WIDTH = 10
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    input  logic [5:0]  OPCODE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        DONE,
    output logic        ERR,
    output logic        BUSY,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_RW_RD,
    output logic [31:0] MEM_DIN,
    input  logic [31:0] MEM_DOUT
);
    // state | meaning
    // IDLE  | waiting for REQ
    // RD    | read cycle on the data memory
    // LFMT  | extract/extend load lane into RDATA
    // MERGE | splice store lane into the read word
    // WR    | single write cycle (MEM_RW_RD=0)
    // ERRS  | rejected request, report ERR
    typedef enum logic [2:0] {IDLE, RD, LFMT, MERGE, WR, ERRS} state_t;

    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
    localparam logic [31:0] LAST_WORD = BASE_WORD + (32'd1 << ADDR_WIDTH) - 32'd1;

    state_t      state;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic [31:0] req_idx;
    logic        legal, aligned, is_load, in_range;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val, merged;

    assign req_idx  = {2'b00, ADDR[31:2]};
    assign in_range = (req_idx >= BASE_WORD) && (req_idx <= LAST_WORD);
    assign BUSY     = (state != IDLE);

    always_comb begin
        legal   = 1'b1;
        aligned = 1'b1;
        is_load = 1'b0;
        case (OPCODE)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load = 1'b1; aligned = ~ADDR[0]; end
            OP_LW:         begin is_load = 1'b1; aligned = (ADDR[1:0] == 2'b00); end
            OP_SB:         aligned = 1'b1;
            OP_SH:         aligned = ~ADDR[0];
            OP_SW:         aligned = (ADDR[1:0] == 2'b00);
            default:       legal = 1'b0;
        endcase
    end

    // Big-endian lanes: byte offset 0 is the most significant byte.
    always_comb begin
        lane_b = 8'h00;
        case (off_q)
            2'd0:    lane_b = MEM_DOUT[31:24];
            2'd1:    lane_b = MEM_DOUT[23:16];
            2'd2:    lane_b = MEM_DOUT[15:8];
            default: lane_b = MEM_DOUT[7:0];
        endcase
        lane_h = off_q[1] ? MEM_DOUT[15:0] : MEM_DOUT[31:16];

        load_val = MEM_DOUT;
        case (op_q)
            OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_val = {24'h000000, lane_b};
            OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_val = {16'h0000, lane_h};
            default: load_val = MEM_DOUT;
        endcase

        merged = MEM_DOUT;
        if (op_q == OP_SH) begin
            merged = off_q[1] ? {MEM_DOUT[31:16], wdata_q} : {wdata_q, MEM_DOUT[15:0]};
        end else begin
            case (off_q)
                2'd0:    merged = {wdata_q[7:0], MEM_DOUT[23:0]};
                2'd1:    merged = {MEM_DOUT[31:24], wdata_q[7:0], MEM_DOUT[15:0]};
                2'd2:    merged = {MEM_DOUT[31:16], wdata_q[7:0], MEM_DOUT[7:0]};
                default: merged = {MEM_DOUT[31:8], wdata_q[7:0]};
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            op_q      <= 6'h00;
            off_q     <= 2'b00;
            wdata_q   <= 16'h0000;
            MEM_ADDR  <= 32'h0;
            MEM_DIN   <= 32'h0;
            MEM_RW_RD <= 1'b1;
            RDATA     <= 32'h0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                IDLE: if (REQ) begin
                    op_q     <= OPCODE;
                    off_q    <= ADDR[1:0];
                    wdata_q  <= WDATA[15:0];
                    MEM_ADDR <= req_idx;
                    if (!legal || !aligned || !in_range) begin
                        state <= ERRS;
                    end else if (is_load || OPCODE != OP_SW) begin
                        state <= RD;
                    end else begin
                        MEM_DIN   <= WDATA;
                        MEM_RW_RD <= 1'b0;
                        state     <= WR;
                    end
                end
                RD:    state <= op_q[3] ? MERGE : LFMT;
                LFMT: begin
                    RDATA <= load_val;
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                MERGE: begin
                    MEM_DIN   <= merged;
                    MEM_RW_RD <= 1'b0;
                    state     <= WR;
                end
                WR: begin
                    MEM_RW_RD <= 1'b1;
                    DONE      <= 1'b1;
                    state     <= IDLE;
                end
                ERRS: begin
                    DONE  <= 1'b1;
                    ERR   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural data memory, vector table with a scoreboard
// queue, back-to-back REQ sequence and reset-during-write sequence.
module tb_mem_access_unit;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

    logic        CLK, RST_N, REQ;
    logic [5:0]  OPCODE;
    logic [31:0] ADDR, WDATA, RDATA, MEM_ADDR, MEM_DIN, MEM_DOUT;
    logic        DONE, ERR, BUSY, MEM_RW_RD;

    mem_access_unit #(.BASE_WORD(32'h4B00), .ADDR_WIDTH(10)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .OPCODE(OPCODE), .ADDR(ADDR),
        .WDATA(WDATA), .RDATA(RDATA), .DONE(DONE), .ERR(ERR), .BUSY(BUSY),
        .MEM_ADDR(MEM_ADDR), .MEM_RW_RD(MEM_RW_RD), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        logic [31:0] waddr;
        logic [31:0] wword;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t sb_q[$];

    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wword = 32'h0;
    logic [31:0] widx;
    logic        w_in;

    assign widx = MEM_ADDR - 32'h4B00;
    assign w_in = (MEM_ADDR >= 32'h4B00) && (MEM_ADDR < 32'h4F00);

    always @(posedge CLK) begin
        MEM_DOUT <= w_in ? mem[widx[9:0]] : 32'h0;
        if (RST_N && !MEM_RW_RD) begin
            wr_cnt     = wr_cnt + 1;
            last_waddr = MEM_ADDR;
            last_wword = MEM_DIN;
            if (w_in) mem[widx[9:0]] = MEM_DIN;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives the request, then waits for DONE and scores it.
    task automatic run_op(input vec_t v, input bit keep_req, input string tag);
        int   n;
        int   wr0;
        vec_t e;
        OPCODE = v.op; ADDR = v.addr; WDATA = v.wdata; REQ = 1'b1;
        sb_q.push_back(v);
        wr0 = wr_cnt;
        @(posedge CLK); #1;
        if (!keep_req) REQ = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!DONE && n < 10);
        e = sb_q.pop_front();
        chk({tag, " done_seen"}, {31'h0, DONE}, 32'h1);
        chk({tag, " latency"}, n, e.lat);
        chk({tag, " err"}, {31'h0, ERR}, {31'h0, e.err});
        chk({tag, " rdata"}, RDATA, e.rdata);
        chk({tag, " busy"}, {31'h0, BUSY}, 32'h0);
        chk({tag, " writes"}, wr_cnt - wr0, e.nwr);
        if (e.nwr > 0) begin
            chk({tag, " waddr"}, last_waddr, e.waddr);
            chk({tag, " wword"}, last_wword, e.wword);
        end
    endtask

    vec_t tbl[19];
    vec_t b2b[4];
    vec_t v;

    initial begin
        int n;
        int wr0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[2]    = 32'd2001;
        mem[1023] = 32'hA5A5_0F0F;

        tbl[0]  = '{OP_LW,  32'h12C08, 32'h0,        32'h0000_07D1, 1'b0, 3, 0, 32'h0,    32'h0};
        tbl[1]  = '{OP_SW,  32'h12C10, 32'hDEADBEEF, 32'h0000_07D1, 1'b0, 2, 1, 32'h4B04, 32'hDEADBEEF};
        tbl[2]  = '{OP_LW,  32'h12C10, 32'h0,        32'hDEADBEEF,  1'b0, 3, 0, 32'h0,    32'h0};
        tbl[3]  = '{OP_SB,  32'h12C11, 32'h55,       32'hDEADBEEF,  1'b0, 4, 1, 32'h4B04, 32'hDE55BEEF};
        tbl[4]  = '{OP_LB,  32'h12C13, 32'h0,        32'hFFFF_FFEF, 1'b0, 3, 0, 32'h0,    32'h0};
        tbl[5]  = '{OP_LBU, 32'h12C13, 32'h0,        32'h0000_00EF, 1'b0, 3, 0, 32'h0,    32'h0};
        tbl[6]  = '{OP_LH,  32'h12C12, 32'h0,        32'hFFFF_BEEF, 1'b0, 3, 0, 32'h0,    32'h0};
        tbl[7]  = '{OP_LW,  32'h12C0A, 32'h0,        32'hFFFF_BEEF, 1'b1, 2, 0, 32'h0,    32'h0};
        tbl[8]  = '{OP_SH,  32'h12C01, 32'h1234,     32'hFFFF_BEEF, 1'b1, 2, 0, 32'h0,    32'h0};
        tbl[9]  = '{OP_LW,  32'h0,     32'h0,        32'hFFFF_BEEF, 1'b1, 2, 0, 32'h0,    32'h0};
        tbl[10] = '{6'h22,  32'h12C08, 32'h0,        32'hFFFF_BEEF, 1'b1, 2, 0, 32'h0,    32'h0};
        tbl[11] = '{OP_SH,  32'h12C10, 32'hAAAA1234, 32'hFFFF_BEEF, 1'b0, 4, 1, 32'h4B04, 32'h1234BEEF};
        tbl[12] = '{OP_LHU, 32'h12C10, 32'h0,        32'h0000_1234, 1'b0, 3, 0, 32'h0,    32'h0};
        tbl[13] = '{OP_LB,  32'h12C11, 32'h0,        32'h0000_0034, 1'b0, 3, 0, 32'h0,    32'h0};
        tbl[14] = '{OP_LW,  32'h13BFC, 32'h0,        32'hA5A5_0F0F, 1'b0, 3, 0, 32'h0,    32'h0};
        tbl[15] = '{OP_LH,  32'h13BFC, 32'h0,        32'hFFFF_A5A5, 1'b0, 3, 0, 32'h0,    32'h0};
        tbl[16] = '{OP_LW,  32'h13C00, 32'h0,        32'hFFFF_A5A5, 1'b1, 2, 0, 32'h0,    32'h0};
        tbl[17] = '{OP_LB,  32'h12BFF, 32'h0,        32'hFFFF_A5A5, 1'b1, 2, 0, 32'h0,    32'h0};
        tbl[18] = '{OP_LW,  32'h12C10, 32'h0,        32'h1234_BEEF, 1'b0, 3, 0, 32'h0,    32'h0};

        b2b[0] = '{OP_SW, 32'h12C20, 32'h11111111, 32'h1234_BEEF, 1'b0, 2, 1, 32'h4B08, 32'h11111111};
        b2b[1] = '{OP_LW, 32'h12C20, 32'h0,        32'h1111_1111, 1'b0, 3, 0, 32'h0,    32'h0};
        b2b[2] = '{OP_SW, 32'h12C20, 32'h22222222, 32'h1111_1111, 1'b0, 2, 1, 32'h4B08, 32'h22222222};
        b2b[3] = '{OP_LW, 32'h12C20, 32'h0,        32'h2222_2222, 1'b0, 3, 0, 32'h0,    32'h0};

        REQ = 1'b0; OPCODE = 6'h0; ADDR = 32'h0; WDATA = 32'h0;
        RST_N = 1'b0;
        #12;
        chk("rst mem_rw_rd", {31'h0, MEM_RW_RD}, 32'h1);
        chk("rst mem_addr", MEM_ADDR, 32'h0);
        chk("rst mem_din", MEM_DIN, 32'h0);
        chk("rst rdata", RDATA, 32'h0);
        chk("rst done", {31'h0, DONE}, 32'h0);
        chk("rst err", {31'h0, ERR}, 32'h0);
        chk("rst busy", {31'h0, BUSY}, 32'h0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 19; i++) run_op(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // REQ held high: each request must be taken only in the DONE cycle of the previous one.
        for (int i = 0; i < 4; i++) run_op(b2b[i], 1'b1, $sformatf("b2b%0d", i));
        REQ = 1'b0;
        @(negedge CLK);
        chk("b2b mem word", mem[8], 32'h2222_2222);

        // Reset asserted while an SB sits in WR.
        OPCODE = OP_SB; ADDR = 32'h12C31; WDATA = 32'h77; REQ = 1'b1;
        wr0 = wr_cnt;
        @(posedge CLK); #1;
        REQ = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (MEM_RW_RD && n < 10);
        chk("rstwr reached_wr", {31'h0, MEM_RW_RD}, 32'h0);
        RST_N = 1'b0;
        #1;
        chk("rstwr mem_rw_rd", {31'h0, MEM_RW_RD}, 32'h1);
        chk("rstwr busy", {31'h0, BUSY}, 32'h0);
        chk("rstwr done", {31'h0, DONE}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge CLK);
            if (DONE) n++;
        end
        chk("rstwr no_done", n, 0);
        chk("rstwr no_write", wr_cnt - wr0, 0);
        v = '{OP_LW, 32'h12C30, 32'h0, 32'h0, 1'b0, 3, 0, 32'h0, 32'h0};
        run_op(v, 1'b0, "rstwr readback");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
